if_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined MIPS core.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for the decode stage.
- Handles decode stalls, branch redirects from execute (with flush), an externally requested halt, and a saturating fetch counter.

---
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID pipeline register, with stall, branch redirect/flush and halt/resume.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_inst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        halt,
    input  logic        resume,
    output logic        ifid_valid,
    output logic [15:0] ifid_inst,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus1,
    output logic [15:0] fetch_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        SLEEP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic        valid_nxt;
    logic [15:0] inst_nxt, ifpc_nxt, ifpc1_nxt, count_nxt;

    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_inst     <= NOP_INST;
            ifid_pc       <= 16'h0000;
            ifid_pc_plus1 <= 16'h0000;
            fetch_count   <= 16'h0000;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            ifid_valid    <= valid_nxt;
            ifid_inst     <= inst_nxt;
            ifid_pc       <= ifpc_nxt;
            ifid_pc_plus1 <= ifpc1_nxt;
            fetch_count   <= count_nxt;
        end
    end

    // One action per RUN cycle, priority branch > halt > stall > capture.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = ifid_valid;
        inst_nxt  = ifid_inst;
        ifpc_nxt  = ifid_pc;
        ifpc1_nxt = ifid_pc_plus1;
        count_nxt = fetch_count;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    valid_nxt = 1'b0;
                    inst_nxt  = NOP_INST;
                    if (halt) state_nxt = SLEEP;
                end else if (halt) begin
                    valid_nxt = 1'b0;
                    inst_nxt  = NOP_INST;
                    state_nxt = SLEEP;
                end else if (!stall) begin
                    valid_nxt = 1'b1;
                    inst_nxt  = imem_inst;
                    ifpc_nxt  = pc;
                    ifpc1_nxt = pc + 16'd1;
                    pc_nxt    = pc + 16'd1;
                    if (fetch_count != 16'hFFFF) count_nxt = fetch_count + 16'd1;
                end
            end
            SLEEP: begin
                // Redirects are still honoured while asleep so resume fetches the target.
                if (br_taken) pc_nxt = br_target;
                if (resume && !halt) state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the fetch stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_inst;
  logic        stall, br_taken, halt, resume;
  logic [15:0] br_target;
  logic        ifid_valid;
  logic [15:0] ifid_inst, ifid_pc, ifid_pc_plus1, fetch_count;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  // Clock and instruction memory (combinational function of address).
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0000) return 16'h9205;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign imem_inst = mem_fn(imem_addr);

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .stall(stall), .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .resume(resume), .ifid_valid(ifid_valid), .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1), .fetch_count(fetch_count),
    .state_dbg(state_dbg)
  );

  // Behavioural model: "booting" / "fetching" / "asleep" flags and plain integers.
  bit          m_booting, m_asleep;
  int          m_pc, m_cnt, m_ifpc, m_ifpc1;
  bit          m_valid;
  logic [15:0] m_inst;
  bit          m_captured;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_booting = 1; m_asleep = 0; m_pc = 0; m_cnt = 0;
    m_ifpc = 0; m_ifpc1 = 0; m_valid = 0; m_inst = 16'h0000;
    m_captured = 0; exp_q.delete();
  endtask

  task automatic model_step(input bit s, input bit b, input logic [15:0] t, input bit h, input bit r);
    m_captured = 0;
    if (m_booting) begin
      m_booting = 0;
    end else if (m_asleep) begin
      if (b) m_pc = t;
      if (r && !h) m_asleep = 0;
    end else if (b || h) begin
      if (b) m_pc = t;
      m_valid = 0; m_inst = 16'h0000;
      if (h) m_asleep = 1;
    end else if (!s) begin
      m_inst = mem_fn(16'(m_pc));
      m_ifpc = m_pc;
      m_ifpc1 = (m_pc + 1) % 65536;
      m_valid = 1;
      exp_q.push_back(16'(m_pc));
      m_pc = (m_pc + 1) % 65536;
      if (m_cnt < 65535) m_cnt++;
      m_captured = 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] sb;
    check("imem_addr", imem_addr, 16'(m_pc));
    check("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
    check("ifid_inst", ifid_inst, m_inst);
    check("ifid_pc", ifid_pc, 16'(m_ifpc));
    check("ifid_pc_plus1", ifid_pc_plus1, 16'(m_ifpc1));
    check("fetch_count", fetch_count, 16'(m_cnt));
    if (m_captured && exp_q.size() > 0) begin
      sb = exp_q.pop_front();
      check("sb_fetch_addr", ifid_pc, sb);
    end
  endtask

  // Driver: apply inputs after an edge, advance model, sample 1 time unit after next edge.
  task automatic step(input bit s, input bit b, input logic [15:0] t, input bit h, input bit r);
    stall = s; br_taken = b; br_target = t; halt = h; resume = r;
    model_step(s, b, t, h, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 0; br_taken = 0; br_target = 0; halt = 0; resume = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();

    // Boot and free-running fetch from address 0.
    do_reset();
    step(0, 0, 16'h0, 0, 0);
    check("boot_no_capture", {15'd0, ifid_valid}, 16'd0);
    step(0, 0, 16'h0, 0, 0);
    check("first_inst", ifid_inst, 16'h9205);
    run(3);
    check("count_after_5", fetch_count, 16'd4);

    // Stall at PC=5 for three cycles.
    run(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, 0, 0);
      check("stall_pc", imem_addr, 16'd5);
    end
    step(0, 0, 16'h0, 0, 0);
    check("stall_release_ifpc", ifid_pc, 16'd5);

    // Branch overrides a simultaneous stall.
    step(0, 1, 16'd34, 0, 0);
    step(1, 1, 16'h0020, 0, 0);
    check("br_pc", imem_addr, 16'h0020);
    step(0, 0, 16'h0, 0, 0);
    check("br_capture", ifid_pc, 16'h0020);

    // Halt at PC=10, sleep with stall noise, then resume.
    step(0, 1, 16'd10, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 4; i++) step(i[0], 0, 16'h0, 0, 0);
    check("sleep_pc", imem_addr, 16'd10);
    step(0, 0, 16'h0, 1, 1);
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 0);
    check("resume_ifpc", ifid_pc, 16'd10);

    // Branch while asleep, and branch+halt together.
    step(0, 1, 16'd50, 1, 0);
    step(0, 1, 16'd60, 0, 0);
    step(0, 0, 16'h0, 0, 1);
    run(2);

    // PC wrap at 16'hFFFF.
    step(0, 1, 16'hFFFF, 0, 0);
    step(0, 0, 16'h0, 0, 0);
    check("wrap_plus1", ifid_pc_plus1, 16'h0000);
    check("wrap_addr", imem_addr, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 16'($urandom),
           $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-cycle with PC=17, fetch_count=12.
    do_reset();
    run(13);
    step(0, 1, 16'd17, 0, 0);
    check("pre_reset_cnt", fetch_count, 16'd12);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    step(1, 1, 16'h1234, 1, 0);
    check("boot_ignores_br", imem_addr, 16'h0000);
    step(0, 0, 16'h0, 0, 0);
    check("post_reset_capture", ifid_inst, 16'h9205);
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
